// File: rtl/frog_pkg.sv
// frog_pkg: shared constants, types and helpers for the frog controller.
//   GRID_W / GRID_H  : playfield size (16x16)
//   START_ROW/COL    : frog start cell (15, 7)
//   frog_state_e     : PLAY, RESPAWN, DEAD, WON
//   sat_step()       : one grid step with saturation at 0 and GRID_H-1
package frog_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;

  localparam logic [3:0] START_ROW = 4'd15;
  localparam logic [3:0] START_COL = 4'd7;
  localparam logic [3:0] GRID_MAX  = 4'(GRID_H - 1);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    RESPAWN = 2'd1,
    DEAD    = 2'd2,
    WON     = 2'd3
  } frog_state_e;

  // Move one cell up (inc=1) or down (inc=0) the 0..GRID_MAX range, never wrapping.
  function automatic logic [3:0] sat_step(input logic [3:0] v, input logic inc);
    logic [3:0] r;
    r = v;
    if (inc) begin
      if (v != GRID_MAX) r = v + 4'd1;
    end else begin
      if (v != 4'd0) r = v - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frog_btn_edge.sv
// btn_edge: 1-bit rising-edge detector producing a registered 1-cycle pulse.
//   clk, reset : clock, synchronous active-high reset
//   btn        : button level, already synchronous to clk
//   pulse      : high for one cycle after each 0->1 transition of btn
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic level_q, level_d;
  logic pulse_q, pulse_d;

  always_comb begin
    level_d = btn;
    pulse_d = btn & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/frog_ctrl.sv
// frog_ctrl: player-frog controller for the 16x16 LED playfield.
// Turns button presses into saturating grid moves, checks the frog cell
// against the car-lane rows every cycle, and tracks lives / win / game over.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   btn_up/down/left/right     : synchronised button levels
//   lane_pixels[LANES][16]     : car rows, bit c = column c occupied
//   frog_row, frog_col         : registered frog position (row 0 = goal)
//   frog_pixels                : one-hot column of the frog, zero when dead
//   hit                        : game-over level to the car lanes
//   win                        : frog reached row 0
//   lives                      : remaining lives
//
// Build option: define FROG_LIVES_EN to enable the multi-life counter and the
// RESPAWN state. Without it the first collision is fatal and lives is 1 / 0.
module frog_ctrl
  import frog_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int LANE_BASE      = 4,
  parameter int RESPAWN_CYCLES = 1024,
  parameter int START_LIVES    = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic [LANES-1:0][GRID_W-1:0] lane_pixels,
  output logic [3:0]                  frog_row,
  output logic [3:0]                  frog_col,
  output logic [GRID_W-1:0]           frog_pixels,
  output logic                        hit,
  output logic                        win,
  output logic [1:0]                  lives
);

`ifdef FROG_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam int         TIMER_W    = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RESPAWN_CYCLES - 1);
`else
  localparam logic [1:0] LIVES_INIT = 2'd1;
`endif

  // Button edge detection: bit order up, down, left, right.
  logic [3:0] btn_lvl;
  logic [3:0] move_pulse;

  assign btn_lvl = {btn_right, btn_left, btn_down, btn_up};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_edge u_edge (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_lvl[gi]),
      .pulse (move_pulse[gi])
    );
  end

  // Registered state.
  frog_state_e       state_q, state_d;
  logic [3:0]        frog_row_q, frog_row_d;
  logic [3:0]        frog_col_q, frog_col_d;
  logic [GRID_W-1:0] pixels_q, pixels_d;
  logic              hit_q, hit_d;
  logic              win_q, win_d;
  logic [1:0]        lives_q, lives_d;
`ifdef FROG_LIVES_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
`endif

  // Per-lane collision test on the registered position; each lane only
  // matches when the frog sits on that lane's row.
  logic [LANES-1:0] lane_hit;
  logic             collide;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [3:0] LANE_ROW = 4'(LANE_BASE + gi);
    assign lane_hit[gi] = (frog_row_q == LANE_ROW) && lane_pixels[gi][frog_col_q];
  end

  assign collide = (state_q == PLAY) && (|lane_hit);

  always_comb begin
    state_d    = state_q;
    frog_row_d = frog_row_q;
    frog_col_d = frog_col_q;
    lives_d    = lives_q;
`ifdef FROG_LIVES_EN
    timer_d    = timer_q;
`endif

    case (state_q)
      PLAY: begin
        // Collision wins over any move pulse in the same cycle.
        if (collide) begin
`ifdef FROG_LIVES_EN
          if (lives_q > 2'd1) begin
            state_d    = RESPAWN;
            lives_d    = lives_q - 2'd1;
            frog_row_d = START_ROW;
            frog_col_d = START_COL;
            timer_d    = '0;
          end else begin
            state_d = DEAD;
            lives_d = 2'd0;
          end
`else
          state_d = DEAD;
          lives_d = 2'd0;
`endif
        end else if (frog_row_q == 4'd0) begin
          state_d = WON;
        end else if (move_pulse[0]) begin
          frog_row_d = sat_step(frog_row_q, 1'b0);
        end else if (move_pulse[1]) begin
          frog_row_d = sat_step(frog_row_q, 1'b1);
        end else if (move_pulse[2]) begin
          frog_col_d = sat_step(frog_col_q, 1'b0);
        end else if (move_pulse[3]) begin
          frog_col_d = sat_step(frog_col_q, 1'b1);
        end
      end
`ifdef FROG_LIVES_EN
      RESPAWN: begin
        if (timer_q == TIMER_LAST) begin
          state_d = PLAY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      DEAD:    state_d = DEAD;
      WON:     state_d = WON;
      default: state_d = PLAY;
    endcase

    // Output flops are loaded from next-state values so they track the state.
    hit_d    = (state_d == DEAD);
    win_d    = (state_d == WON);
    pixels_d = (state_d == DEAD) ? '0 : (GRID_W'(1) << frog_col_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PLAY;
      frog_row_q <= START_ROW;
      frog_col_q <= START_COL;
      pixels_q   <= GRID_W'(1) << START_COL;
      hit_q      <= 1'b0;
      win_q      <= 1'b0;
      lives_q    <= LIVES_INIT;
`ifdef FROG_LIVES_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      frog_row_q <= frog_row_d;
      frog_col_q <= frog_col_d;
      pixels_q   <= pixels_d;
      hit_q      <= hit_d;
      win_q      <= win_d;
      lives_q    <= lives_d;
`ifdef FROG_LIVES_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign frog_row    = frog_row_q;
  assign frog_col    = frog_col_q;
  assign frog_pixels = pixels_q;
  assign hit         = hit_q;
  assign win         = win_q;
  assign lives       = lives_q;

endmodule

// File: doc/frog_ctrl.md
# frog_ctrl

Player-frog controller for the 16x16 LED playfield. It converts button presses into frog grid moves and tests the frog cell against the car-lane pixel rows every cycle. It drives the `hit` input of every car-lane block. It also tracks lives and the win/lose outcome for the display and top-level stages.

## Interface

Parameters:
- `LANES`, 4: number of car lanes checked.
- `LANE_BASE`, 4: grid row occupied by lane 0; lane i occupies row `LANE_BASE+i`.
- `RESPAWN_CYCLES`, 1024: hold time after a non-fatal collision.
- `START_LIVES`, 3: lives loaded at reset; used only with `FROG_LIVES_EN`.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` input 1 each: button levels, already synchronised to `clk`.
- `lane_pixels` input `[LANES-1:0][15:0]`: car rows; bit c is column c, 1 means car present.
- `frog_row` output 4: current row; 0 is the top/goal row.
- `frog_col` output 4: current column.
- `frog_pixels` output 16: one-hot on `frog_col`; all zero in DEAD.
- `hit` output 1: game-over level to the car lanes.
- `win` output 1: frog reached row 0.
- `lives` output 2: remaining lives.

## Operation

- **Reset:**
  - State = PLAY, `frog_row`=15, `frog_col`=7.
  - `hit`=0, `win`=0.
  - `lives`=`START_LIVES` (with macro) or 1 (without).
- **Button handling:** each button is rising-edge detected and produces a 1-cycle move pulse. Holding a button yields a single move.
- **Simultaneous pulses:** only one move per cycle, with priority up > down > left > right.
- **Moves in PLAY:**
  - up: row-1.
  - down: row+1.
  - left: col-1.
  - right: col+1.
  - All moves saturate at 0 and 15; there is no wrap-around.
- **Collision:**
  - `collide` is true when `frog_row` is in [`LANE_BASE`, `LANE_BASE+LANES-1`] and `lane_pixels[frog_row-LANE_BASE][frog_col]`=1.
  - It is evaluated on the registered position, in PLAY only.
- **State machine:**
  - PLAY → WON when `frog_row`==0; `win`=1.
  - PLAY → DEAD on `collide` with `lives`==1; `lives`=0, `hit`=1.
  - PLAY → RESPAWN on `collide` with `lives`>1 (macro only); `lives`-1, position returns to start (15,7), and the respawn timer is cleared.
  - Collision takes precedence over a move pulse in the same cycle.
  - RESPAWN: moves are ignored and collision is masked. The timer counts to `RESPAWN_CYCLES-1`, then the state returns to PLAY.
  - DEAD and WON are terminal until reset. Moves are ignored. `hit` stays 1 in DEAD; `win` stays 1 in WON.
- `reset` in any state, including mid-RESPAWN, restores the reset values on the next edge.

## Timing

- Button rising edge at cycle n: the edge pulse is registered at n+1, and `frog_row`/`frog_col` update at n+2.
- Collision present on the registered position at cycle n: the state, `lives` and `hit` update at n+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- RESPAWN lasts exactly `RESPAWN_CYCLES` cycles.

## Configuration

- `FROG_LIVES_EN` defined:
  - The lives counter loads `START_LIVES`.
  - RESPAWN state is present.
  - `hit` is raised only on the final life.
- `FROG_LIVES_EN` undefined:
  - RESPAWN state and timer are removed.
  - `lives` is fixed at 1 until death and 0 in DEAD.
  - The first collision goes straight to DEAD.

## Structure

- **Package `frog_pkg`:**
  - `GRID_W`=16, `GRID_H`=16.
  - Start position constants (15, 7).
  - The state enum {PLAY, RESPAWN, DEAD, WON}.
- **Sub-module `btn_edge`:** 1-bit rising-edge detector, instantiated four times.

## Test plan

- **Reset and start position:** reset, then all lanes zero. Expect `frog_row`=15, `frog_col`=7, `frog_pixels`=16'h0080, `hit`=0, `lives`=3.
- **Edge detection and saturation:**
  - Hold `btn_left` for 20 cycles: expect exactly one move, to col 6.
  - Then press right 10 times: col saturates at 15.
- **Priority:** pulse up and right in the same cycle → row 14, col unchanged at 7.
- **Non-fatal collision (macro on):**
  - Setup: frog at row 4, col 7; set `lane_pixels[0]`=16'h0080.
  - Expect the next cycle: RESPAWN, `lives`=2, position (15,7), `hit`=0.
  - Moves are ignored for 1024 cycles, then accepted.
- **Final collision:**
  - With `lives`=1, collide again. Expect `hit`=1 and `frog_pixels`=0 held.
  - Then assert `reset`: `hit`=0 and `lives`=3 on the next edge.
- **Win:** 15 up presses on clear lanes → `frog_row`=0, `win`=1; later presses ignored.
